// File: rtl/rr_burst_pkg.sv
// ----------------------------------------------------------------------------
// rr_burst_pkg
// Shared types and helpers for the round-robin burst sequencer.
//   state_t        : sequencer states (IDLE / GRANT / RELEASE)
//   MAX_REQ        : widest requester vector the helpers support (16)
//   IDX_W          : width of a requester index for the helpers
//   mask_after()   : preference mask after owner k is released, (1<<k)-1
//   onehot_to_idx(): index of the set bit in a one-hot vector
// ----------------------------------------------------------------------------
package rr_burst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    // Only indices strictly below the released owner stay preferred.
    // Owner 0 yields an empty mask, which forces the raw wrap-around pick.
    function automatic logic [MAX_REQ-1:0] mask_after(input logic [IDX_W-1:0] owner);
        return (MAX_REQ'(1) << owner) - MAX_REQ'(1);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_burst_sequencer_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection, highest index wins.
// Ports:
//   req   : raw request vector
//   mask  : preference mask; masked candidates win when any exist
//   pick  : one-hot winner (zero when req is zero)
//   valid : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [NUM_REQ-1:0] masked_req;
    logic [NUM_REQ-1:0] masked_pick;
    logic [NUM_REQ-1:0] raw_pick;

    assign masked_req = req & mask;

    // Two highest-index priority encoders: the ascending scan lets the
    // highest set bit overwrite any lower one.
    always_comb begin
        masked_pick = '0;
        raw_pick    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (masked_req[i]) begin
                masked_pick    = '0;
                masked_pick[i] = 1'b1;
            end
            if (req[i]) begin
                raw_pick    = '0;
                raw_pick[i] = 1'b1;
            end
        end
    end

    // An empty masked set means the rotation has wrapped past index 0.
    assign pick  = (|masked_req) ? masked_pick : raw_pick;
    assign valid = |req;

endmodule

// File: rtl/rr_burst_sequencer.sv
// ----------------------------------------------------------------------------
// rr_burst_sequencer
// Shares one burst-capable resource among NUM_REQ requesters. The grant is
// registered, round-robin selected and held for a whole burst; it is
// released on the owner's last beat, the MAX_BURST beat cap, or the owner
// dropping its request. A dead cycle separates owners.
// Optional feature macro RR_BACK2BACK_EN: when defined, a release with
// another request pending hands the grant straight to the next owner with
// no dead cycle.
// Ports:
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   req_i      : per-requester request level
//   beat_i     : resource accepted a beat from the owner this cycle
//   last_i     : owner marks this beat as final (qualified by beat_i)
//   gnt_o      : registered one-hot grant, or zero
//   busy_o     : high while a grant is held
//   owner_o    : index of the current / last owner
//   beat_cnt_o : beats completed in the current grant
// ----------------------------------------------------------------------------
module rr_burst_sequencer
    import rr_burst_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       beat_i,
    input  logic                       last_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic [CNT_W-1:0]           beat_cnt_o
);

    localparam int OW = $clog2(NUM_REQ);

    state_t             state_q;
    state_t             state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [OW-1:0]      owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] mask_q;
    logic [NUM_REQ-1:0] mask_next;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic               owner_req;
    logic               release_evt;
    logic               load_grant;

    assign mask_next = NUM_REQ'(mask_after(IDX_W'(owner_q)));
    assign owner_req = |(req_i & gnt_q);

    // The beat that hits MAX_BURST-1 completed beats is the capping beat.
    assign release_evt = (state_q == GRANT) &&
                         ((beat_i && last_i) ||
                          (beat_i && (cnt_q == CNT_W'(MAX_BURST - 1))) ||
                          !owner_req);

`ifdef RR_BACK2BACK_EN
    // During the release cycle the outgoing owner is excluded and the
    // post-release mask is used, so the handover follows the rotation.
    assign pick_req  = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;
    assign pick_mask = (state_q == GRANT) ? mask_next : mask_q;
`else
    assign pick_req  = req_i;
    assign pick_mask = mask_q;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (pick_req),
        .mask  (pick_mask),
        .pick  (pick_oh),
        .valid (pick_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_grant marks the edge that latches a new owner.
    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (release_evt) begin
`ifdef RR_BACK2BACK_EN
                    if (pick_valid) begin
                        state_d    = GRANT;
                        load_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = RELEASE;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant, owner, beat counter and mask registers. A new grant overrides
    // the release clear and the beat increment of the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            mask_q  <= '1;
        end else begin
            if (state_q == GRANT && beat_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (release_evt) begin
                gnt_q  <= '0;
                mask_q <= mask_next;
            end
            if (load_grant) begin
                gnt_q   <= pick_oh;
                owner_q <= OW'(onehot_to_idx(MAX_REQ'(pick_oh)));
                cnt_q   <= '0;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt_o      = gnt_q;
        busy_o     = |gnt_q;
        owner_o    = owner_q;
        beat_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_rr_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rr_burst_sequencer
// Self-checking bench for rr_burst_sequencer (NUM_REQ=4, MAX_BURST=8).
// A behavioural model tracks the owner, beat count and preference limit
// and is compared against the DUT after every clock edge; directed
// scenarios add fixed expectations, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_rr_burst_sequencer;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int CW = $clog2(MB + 1);

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_i;
    logic              beat_i;
    logic              last_i;
    logic [N-1:0]      gnt_o;
    logic              busy_o;
    logic [$clog2(N)-1:0] owner_o;
    logic [CW-1:0]     beat_cnt_o;

    int checks_total;
    int checks_passed;

    // Model: busy/owner/count of the live grant, a pending dead cycle and
    // the preference limit (indices below the limit are preferred).
    int m_busy;
    int m_dead;
    int m_owner;
    int m_cnt;
    int m_limit;

    rr_burst_sequencer #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .beat_i     (beat_i),
        .last_i     (last_i),
        .gnt_o      (gnt_o),
        .busy_o     (busy_o),
        .owner_o    (owner_o),
        .beat_cnt_o (beat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int pickWinner(input logic [N-1:0] r, input int limit);
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i] && i < limit) return i;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_busy  = 0;
        m_dead  = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_limit = N;
    endtask

    task automatic modelStep(input logic [N-1:0] r, input logic b, input logic l);
        int prev;
        int w;
        bit rel;
        logic [N-1:0] others;
        if (m_busy != 0) begin
            prev = m_cnt;
            if (b) m_cnt++;
            rel = (b && l) || (b && prev == MB - 1) || !r[m_owner];
            if (rel) begin
                m_limit = m_owner;
                m_busy  = 0;
`ifdef RR_BACK2BACK_EN
                others = r;
                others[m_owner] = 1'b0;
                w = pickWinner(others, m_limit);
                if (w >= 0) begin
                    m_busy  = 1;
                    m_owner = w;
                    m_cnt   = 0;
                end
`else
                others = '0;
                m_dead = 1;
`endif
            end
        end else if (m_dead != 0) begin
            m_dead = 0;
        end else begin
            w = pickWinner(r, m_limit);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic compareAll(input string tag);
        logic [N-1:0] exp_gnt;
        exp_gnt = (m_busy != 0) ? N'(1 << m_owner) : '0;
        checkOutput({tag, "_gnt"},   32'(gnt_o),      32'(exp_gnt));
        checkOutput({tag, "_busy"},  32'(busy_o),     32'(m_busy));
        checkOutput({tag, "_owner"}, 32'(owner_o),    32'(m_owner));
        checkOutput({tag, "_cnt"},   32'(beat_cnt_o), 32'(m_cnt));
    endtask

    // Drives one cycle of inputs, advances the model at the edge and
    // compares just after it.
    task automatic applyStimulus(input string tag, input logic [N-1:0] r,
                                 input logic b, input logic l);
        req_i  = r;
        beat_i = b;
        last_i = l;
        @(posedge clk);
        modelStep(r, b, l);
        #1;
        compareAll(tag);
    endtask

    // Entered just after a rising edge; leaves reset released on a falling edge.
    task automatic doReset();
        req_i  = '0;
        beat_i = 1'b0;
        last_i = 1'b0;
        reset  = 1'b0;
        #2;
        modelReset();
        compareAll("rst");
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] order [5];
        logic [N-1:0] r;
        int waited;

        checks_total  = 0;
        checks_passed = 0;
        reset  = 1'b1;
        req_i  = '0;
        beat_i = 1'b0;
        last_i = 1'b0;
        modelReset();
        #6;

        // Full rotation with two-beat bursts.
        doReset();
        order[0] = 4'b1000;
        order[1] = 4'b0100;
        order[2] = 4'b0010;
        order[3] = 4'b0001;
        order[4] = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            waited = 0;
            while (gnt_o == '0 && waited < 4) begin
                applyStimulus("t1_wait", 4'hF, 1'b0, 1'b0);
                waited++;
            end
            checkOutput("t1_order", 32'(gnt_o), 32'(order[i]));
            applyStimulus("t1_beat", 4'hF, 1'b1, 1'b0);
            applyStimulus("t1_last", 4'hF, 1'b1, 1'b1);
`ifndef RR_BACK2BACK_EN
            checkOutput("t1_cnt", 32'(beat_cnt_o), 32'd2);
`endif
        end

        // Beat cap with a lone requester, then raw wrap-around regrant.
        doReset();
        applyStimulus("t2_grant", 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < MB; i++) begin
            applyStimulus("t2_beat", 4'b0001, 1'b1, 1'b0);
        end
        checkOutput("t2_cap_cnt", 32'(beat_cnt_o), 32'd8);
        checkOutput("t2_cap_gnt", 32'(gnt_o), 32'd0);
        applyStimulus("t2_dead", 4'b0001, 1'b0, 1'b0);
        applyStimulus("t2_pick", 4'b0001, 1'b0, 1'b0);
        checkOutput("t2_regrant", 32'(gnt_o), 32'b0001);

        // Owner 2 drops its request mid-burst.
        doReset();
        applyStimulus("t3_grant", 4'b0100, 1'b0, 1'b0);
        checkOutput("t3_owner2", 32'(gnt_o), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t3_beat", 4'b1101, 1'b1, 1'b0);
        end
        applyStimulus("t3_drop", 4'b1001, 1'b0, 1'b0);
`ifndef RR_BACK2BACK_EN
        checkOutput("t3_drop_gnt", 32'(gnt_o), 32'd0);
        checkOutput("t3_drop_cnt", 32'(beat_cnt_o), 32'd3);
`endif
        waited = 0;
        while (gnt_o == '0 && waited < 4) begin
            applyStimulus("t3_wait", 4'b1001, 1'b0, 1'b0);
            waited++;
        end
        checkOutput("t3_next", 32'(gnt_o), 32'b0001);

        // Asynchronous reset in the middle of owner 2's burst.
        doReset();
        applyStimulus("t4_a", 4'hF, 1'b0, 1'b0);
        applyStimulus("t4_b", 4'hF, 1'b1, 1'b1);
        applyStimulus("t4_c", 4'hF, 1'b0, 1'b0);
        applyStimulus("t4_d", 4'hF, 1'b0, 1'b0);
        checkOutput("t4_pre", 32'(gnt_o), 32'b0100);
        applyStimulus("t4_e", 4'hF, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("t4_async_gnt", 32'(gnt_o), 32'd0);
        checkOutput("t4_async_busy", 32'(busy_o), 32'd0);
        modelReset();
        #3;
        reset = 1'b1;
        applyStimulus("t4_first", 4'hF, 1'b0, 1'b0);
        checkOutput("t4_first_gnt", 32'(gnt_o), 32'b1000);

        // Beats outside a grant are ignored.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t5_idle", 4'b0000, 1'b1, 1'b1);
        end
        checkOutput("t5_cnt", 32'(beat_cnt_o), 32'd0);
        checkOutput("t5_gnt", 32'(gnt_o), 32'd0);

`ifdef RR_BACK2BACK_EN
        // Back-to-back handover with single-beat bursts.
        doReset();
        applyStimulus("t6_first", 4'hF, 1'b0, 1'b0);
        checkOutput("t6_gnt0", 32'(gnt_o), 32'b1000);
        for (int i = 1; i < 4; i++) begin
            applyStimulus("t6_hand", 4'hF, 1'b1, 1'b1);
            checkOutput("t6_gnt", 32'(gnt_o), 32'(order[i]));
            checkOutput("t6_busy", 32'(busy_o), 32'd1);
        end
`endif

        // Randomized traffic against the model.
        doReset();
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = N'($urandom);
            end
            applyStimulus("rnd", r, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
